// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, counter type and the
// alignment bundle carried through the ROM-latency pipeline.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int ROM_LAT_DEF  = 2;
  localparam int CNT_W        = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
  } tim_t;

  function automatic int total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  localparam int H_TOTAL =
    total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL =
    total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/delay_line.sv
// Fixed-depth register pipeline with a per-bit reset value,
// used to align timing strobes with the ROM read latency.
module delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= RST_VAL;
      end
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster scanner: h/v counters, tile ROM addressing and
// sync/colour outputs aligned to the ROM read latency.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int ROM_LAT  = ROM_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_en,
  output logic [6:0]  rom_x,
  output logic [5:0]  rom_y,
  input  logic [11:0] rom_color,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int HT = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam cnt_t H_LAST = cnt_t'(HT - 1);
  localparam cnt_t V_LAST = cnt_t'(VT - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_LO  = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_HI  = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_LO  = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_HI  = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  localparam tim_t TIM_RST = '{
    act: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0
  };

  cnt_t        h_q, h_d;
  cnt_t        v_q, v_d;
  logic        active;
  logic        act_q;
  tim_t        tim_c;
  tim_t        tim_dly;
  logic [11:0] rgb_q;
  logic        hs_q;
  logic        vs_q;
  logic        fs_q;

  always_comb begin
    h_d = h_q + cnt_t'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q   <= '0;
      v_q   <= '0;
      act_q <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      act_q <= active;
    end
  end

  assign active = (h_q < H_ACT) && (v_q < V_ACT);

  // Held off in reset; one extra clock flushes the last pixel
  assign rom_en = (active | act_q) & rst_n;
  assign rom_x  = h_q[9:3];
  assign rom_y  = v_q[8:3];

  always_comb begin
    tim_c     = TIM_RST;
    tim_c.act = active;
    tim_c.hs  = !((h_q >= HS_LO) && (h_q < HS_HI));
    tim_c.vs  = !((v_q >= VS_LO) && (v_q < VS_HI));
    tim_c.fs  = (h_q == '0) && (v_q == '0);
  end

  delay_line #(
    .WIDTH   ($bits(tim_t)),
    .DEPTH   (ROM_LAT),
    .RST_VAL (TIM_RST)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (tim_c),
    .q_o   (tim_dly)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      rgb_q <= tim_dly.act ? rom_color : '0;
      hs_q  <= tim_dly.hs;
      vs_q  <= tim_dly.vs;
      fs_q  <= tim_dly.fs;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;

endmodule
